ds_mem_sequencer: RTL

//  Upstream/downstream stage around the downsampling Processor; owns the data-memory port and drives status[1:0].

---
 rtl/ds_mem_pkg.sv | 32 +++
 rtl/ds_addr_counter.sv | 31 +++
 rtl/ds_mem_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ds_mem_pkg.sv
// Shared status codes, FSM state encoding and width defaults for the data-memory sequencer.
package ds_mem_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_PROC = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_DUMP = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_LOAD      = 3'd1;
  localparam state_t S_PROC      = 3'd2;
  localparam state_t S_DUMP_RD   = 3'd3;
  localparam state_t S_DUMP_WAIT = 3'd4;
  localparam state_t S_DUMP_TX   = 3'd5;
  localparam state_t S_DONE      = 3'd6;

  // DONE reports idle so the Processor sees the handover as soon as the last byte leaves.
  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      S_LOAD:                           return ST_LOAD;
      S_PROC:                           return ST_PROC;
      S_DUMP_RD, S_DUMP_WAIT, S_DUMP_TX: return ST_DUMP;
      default:                          return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ds_addr_counter.sv
// Byte counter shared by the load and dump phases: synchronous clear, increment,
// and a compare against the caller-supplied terminal count.
module ds_addr_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         at_term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/ds_mem_sequencer.sv
// Load / process / dump sequencer owning the single data-memory port around the downsampler.
// Optional DS_CHECKSUM_EN adds running mod-2^16 sums of loaded and transmitted bytes.
module ds_mem_sequencer
  import ds_mem_pkg::*;
#(
  parameter int              ADDR_W     = ADDR_W_DEF,
  parameter int              DATA_W     = DATA_W_DEF,
  parameter int              IMG_PIXELS = 65536,
  parameter logic [ADDR_W-1:0] OUT_BASE = 'h10000,
  parameter int              OUT_PIXELS = 16384
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [1:0]        status,
  input  logic              end_process,
  input  logic              p_dm_r,
  input  logic              p_dm_wr,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done
`ifdef DS_CHECKSUM_EN
  ,
  output logic [15:0]       load_sum,
  output logic [15:0]       dump_sum
`endif
);

  localparam int MAX_PIX = (IMG_PIXELS > OUT_PIXELS) ? IMG_PIXELS : OUT_PIXELS;
  localparam int CNT_W   = $clog2(MAX_PIX) + 1;

  state_t            state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              tx_valid_q, tx_valid_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic [CNT_W-1:0]  cnt, term;
  logic              at_term, cnt_clr, cnt_inc;
  logic              load_hs, tx_hs, start_hs;

  assign start_hs = (state_q == S_IDLE) && start;
  assign load_hs  = (state_q == S_LOAD) && rx_valid && rx_ready_q;
  assign tx_hs    = (state_q == S_DUMP_TX) && tx_valid_q && tx_ready;

  assign term    = (state_q == S_LOAD) ? CNT_W'(IMG_PIXELS - 1) : CNT_W'(OUT_PIXELS - 1);
  assign cnt_clr = start_hs || ((state_q == S_PROC) && end_process);
  assign cnt_inc = load_hs || tx_hs;

  ds_addr_counter #(.W(CNT_W)) u_cnt (
    .clk_i     (clock),
    .rst_n_i   (reset_n),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .term_i    (term),
    .cnt_o     (cnt),
    .at_term_o (at_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start)              state_d = S_LOAD;
      S_LOAD:      if (load_hs && at_term) state_d = S_PROC;
      S_PROC:      if (end_process)        state_d = S_DUMP_RD;
      S_DUMP_RD:                           state_d = S_DUMP_WAIT;
      S_DUMP_WAIT:                         state_d = S_DUMP_TX;
      S_DUMP_TX:   if (tx_hs)              state_d = at_term ? S_DONE : S_DUMP_RD;
      S_DONE:                              state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered off the next state so they line up with the phase.
  assign rx_ready_d = (state_d == S_LOAD);
  assign tx_valid_d = (state_d == S_DUMP_TX);
  assign done_d     = (state_d == S_DONE);
  assign tx_data_d  = (state_q == S_DUMP_WAIT) ? mem_rdata : tx_data_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state_q)
      S_LOAD: begin
        mem_we    = load_hs;
        mem_addr  = ADDR_W'(cnt);
        mem_wdata = rx_data;
      end
      S_PROC: begin
        mem_we    = p_dm_wr;
        mem_re    = p_dm_r;
        mem_addr  = p_addr;
        mem_wdata = p_wdata;
      end
      S_DUMP_RD: begin
        mem_re   = 1'b1;
        mem_addr = OUT_BASE + ADDR_W'(cnt);
      end
      default: ;
    endcase
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign done     = done_q;
  assign status   = status_of(state_q);
  assign p_rdata  = mem_rdata;

`ifdef DS_CHECKSUM_EN
  logic [15:0] load_sum_q, dump_sum_q;

  always_ff @(posedge clock) begin
    if (!reset_n || start_hs) begin
      load_sum_q <= '0;
      dump_sum_q <= '0;
    end else begin
      if (load_hs) load_sum_q <= load_sum_q + 16'(rx_data);
      if (tx_hs)   dump_sum_q <= dump_sum_q + 16'(tx_data_q);
    end
  end

  assign load_sum = load_sum_q;
  assign dump_sum = dump_sum_q;
`endif

endmodule
